// File: rtl/multicycle_sequencer.sv
// ============================================================================
// Module   : multicycle_sequencer
// Brief    : FETCH/DECODE/EXEC/WB control sequencer with multiplier handshake,
//            timeout, illegal-opcode trap and HALT; Moore-decoded enables.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_sequencer #(
  parameter int INSTR_W      = 16,
  parameter int OPC_W        = 4,
  parameter int STEP_W       = 4,
  parameter int MULT_TIMEOUT = 15
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_run,
  input  logic               i_clr,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic               i_mult_done,
  output logic               o_pc_en,
  output logic               o_ir_ld,
  output logic               o_rf_en,
  output logic               o_mult_en,
  output logic               o_mem_en,
  output logic               o_mem_we,
  output logic               o_wb_sel,
  output logic [2:0]         o_oap,
  output logic [STEP_W-1:0]  o_step,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXEC      = 3'd3;
  localparam logic [2:0] S_WAIT_MULT = 3'd4;
  localparam logic [2:0] S_WB        = 3'd5;
  localparam logic [2:0] S_HALT      = 3'd6;
  localparam logic [2:0] S_ERR       = 3'd7;

  localparam logic [OPC_W-1:0]  C_OPC_MUL    = OPC_W'(4);
  localparam logic [OPC_W-1:0]  C_OPC_LD     = OPC_W'(5);
  localparam logic [OPC_W-1:0]  C_OPC_ST     = OPC_W'(6);
  localparam logic [OPC_W-1:0]  C_OPC_HALT   = OPC_W'(7);
  localparam logic [STEP_W-1:0] C_STEP_MAX   = '1;
  localparam logic [STEP_W-1:0] C_CNT_LAST   = STEP_W'(MULT_TIMEOUT - 1);

  logic [2:0]        r_state;
  logic [2:0]        w_next_state;
  logic [OPC_W-1:0]  r_opc;
  logic [OPC_W-1:0]  w_dec_opc;
  logic [STEP_W-1:0] r_step;
  logic [STEP_W-1:0] w_next_step;
  logic [STEP_W-1:0] r_cnt;
  logic              w_next_busy;
  logic              w_instr_unused;

  assign w_dec_opc      = i_instr[INSTR_W-1 -: OPC_W];
  assign w_instr_unused = ^i_instr[INSTR_W-OPC_W-1:0];

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      if (i_run) w_next_state = S_FETCH;
      S_FETCH:     w_next_state = S_DECODE;
      S_DECODE: begin
        if (w_dec_opc > C_OPC_HALT)       w_next_state = S_ERR;
        else if (w_dec_opc == C_OPC_HALT) w_next_state = S_HALT;
        else                              w_next_state = S_EXEC;
      end
      S_EXEC: begin
        if (r_opc == C_OPC_MUL)     w_next_state = S_WAIT_MULT;
        else if (r_opc == C_OPC_ST) w_next_state = i_run ? S_FETCH : S_IDLE;
        else                        w_next_state = S_WB;
      end
      // Done wins over timeout on the final allowed wait cycle.
      S_WAIT_MULT: begin
        if (i_mult_done)              w_next_state = S_WB;
        else if (r_cnt == C_CNT_LAST) w_next_state = S_ERR;
      end
      S_WB:        w_next_state = i_run ? S_FETCH : S_IDLE;
      default:     w_next_state = r_state;
    endcase
  end

  assign w_next_busy = (w_next_state != S_IDLE) && (w_next_state != S_HALT) &&
                       (w_next_state != S_ERR);

  always_comb begin
    w_next_step = '0;
    if (w_next_busy && (w_next_state != S_FETCH))
      w_next_step = (r_step == C_STEP_MAX) ? C_STEP_MAX : r_step + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_opc   <= '0;
      r_step  <= '0;
      r_cnt   <= '0;
    end else if (i_clr) begin
      r_state <= S_IDLE;
      r_opc   <= '0;
      r_step  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_step  <= w_next_step;
      if (r_state == S_DECODE)
        r_opc <= w_dec_opc;
      if (r_state == S_EXEC)
        r_cnt <= '0;
      else if ((r_state == S_WAIT_MULT) && !i_mult_done)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    o_pc_en   = 1'b0;
    o_ir_ld   = 1'b0;
    o_rf_en   = 1'b0;
    o_mult_en = 1'b0;
    o_mem_en  = 1'b0;
    o_mem_we  = 1'b0;
    o_wb_sel  = 1'b0;
    o_oap     = 3'b000;
    o_done    = 1'b0;
    o_err     = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_pc_en = 1'b1;
        o_ir_ld = 1'b1;
      end
      S_EXEC: begin
        if (r_opc < C_OPC_MUL)      o_oap = {1'b0, r_opc[1:0]};
        else if (r_opc == C_OPC_MUL) o_mult_en = 1'b1;
        else if (r_opc == C_OPC_LD)  o_mem_en = 1'b1;
        else if (r_opc == C_OPC_ST) begin
          o_mem_en = 1'b1;
          o_mem_we = 1'b1;
        end
      end
      S_WB: begin
        o_rf_en  = 1'b1;
        o_wb_sel = (r_opc == C_OPC_LD);
      end
      S_HALT:  o_done = 1'b1;
      S_ERR:   o_err  = 1'b1;
      default: ;
    endcase
  end

  assign o_busy = (r_state != S_IDLE) && (r_state != S_HALT) && (r_state != S_ERR);
  assign o_step = r_step;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
// ============================================================================
// Module   : tb_multicycle_sequencer
// Brief    : Randomised self-checking bench; expected per-cycle output traces
//            are built from the instruction timing rules.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, run, clr, mult_done;
  logic [15:0] instr;
  logic        pc_en, ir_ld, rf_en, mult_en, mem_en, mem_we, wb_sel, busy, done, err;
  logic [2:0]  oap;
  logic [3:0]  step;

  typedef struct packed {
    logic       pc_en, ir_ld, rf_en, mult_en, mem_en, mem_we, wb_sel;
    logic [2:0] oap;
    logic [3:0] step;
    logic       busy, done, err;
  } out_t;

  out_t obs;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  multicycle_sequencer #(
    .INSTR_W(16), .OPC_W(4), .STEP_W(4), .MULT_TIMEOUT(15)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_clr(clr), .i_instr(instr),
    .i_mult_done(mult_done), .o_pc_en(pc_en), .o_ir_ld(ir_ld), .o_rf_en(rf_en),
    .o_mult_en(mult_en), .o_mem_en(mem_en), .o_mem_we(mem_we), .o_wb_sel(wb_sel),
    .o_oap(oap), .o_step(step), .o_busy(busy), .o_done(done), .o_err(err)
  );

  assign obs = {pc_en, ir_ld, rf_en, mult_en, mem_en, mem_we, wb_sel, oap, step, busy, done, err};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic out_t busy_cyc(input int s);
    out_t c;
    c      = '0;
    c.busy = 1'b1;
    c.step = 4'((s > 15) ? 15 : s);
    return c;
  endfunction

  // Expects the DUT to be in FETCH on entry. nwait = cycle of MULT_DONE, 0 = never.
  task automatic run_instr(input logic [3:0] opc, input int nwait, input bit run_end,
                           input string name);
    out_t q[$];
    out_t c;
    int   nw;
    bit   terminal;
    nw       = (nwait == 0) ? 15 : nwait;
    terminal = 1'b0;
    c = busy_cyc(0); c.pc_en = 1'b1; c.ir_ld = 1'b1; q.push_back(c);
    q.push_back(busy_cyc(1));
    if (opc > 7) begin
      c = '0; c.err = 1'b1; q.push_back(c); terminal = 1'b1;
    end else if (opc == 7) begin
      c = '0; c.done = 1'b1; q.push_back(c); terminal = 1'b1;
    end else begin
      c = busy_cyc(2);
      if (opc < 4)       c.oap = {1'b0, opc[1:0]};
      else if (opc == 4) c.mult_en = 1'b1;
      else if (opc == 5) c.mem_en = 1'b1;
      else begin c.mem_en = 1'b1; c.mem_we = 1'b1; end
      q.push_back(c);
      if (opc == 4) begin
        for (int w = 1; w <= nw; w++) q.push_back(busy_cyc(2 + w));
        if (nwait == 0) begin
          c = '0; c.err = 1'b1; q.push_back(c); terminal = 1'b1;
        end
      end
      if (opc != 6 && !terminal) begin
        c = busy_cyc(q.size()); c.rf_en = 1'b1; c.wb_sel = (opc == 5); q.push_back(c);
      end
    end

    instr = {opc, 12'($urandom)};
    for (int k = 0; k < q.size(); k++) begin
      total++;
      if (obs !== q[k]) begin
        bad++;
        $display("FAIL %s opc=%0d cycle=%0d got=%h want=%h", name, opc, k, obs, q[k]);
      end
      run       = 1'($urandom);
      mult_done = 1'($urandom);
      if (opc == 4 && k >= 3 && k < 3 + nw) mult_done = (nwait != 0) && (k - 2 == nwait);
      if (k == q.size() - 1 && !terminal) run = run_end;
      tick;
    end

    if (terminal) begin
      for (int h = 0; h < 3; h++) begin
        total++;
        if (obs !== q[q.size()-1]) begin
          bad++;
          $display("FAIL %s_hold h=%0d got=%h want=%h", name, h, obs, q[q.size()-1]);
        end
        run = 1'($urandom);
        tick;
      end
      clr = 1'b1;
      tick;
      clr = 1'b0;
      run = 1'b0;
      total++;
      if (obs !== out_t'(0)) begin
        bad++;
        $display("FAIL %s_clr got=%h want=%h", name, obs, out_t'(0));
      end
    end else if (!run_end) begin
      total++;
      if (obs !== out_t'(0)) begin
        bad++;
        $display("FAIL %s_idle got=%h want=%h", name, obs, out_t'(0));
      end
    end
  endtask

  task automatic start_from_idle;
    run = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    out_t c;
    rst_n = 1'b0; run = 1'b1; clr = 1'b0; mult_done = 1'b0; instr = 16'h1234;
    for (int i = 0; i < 2; i++) begin
      tick;
      total++;
      if (obs !== out_t'(0)) begin
        bad++;
        $display("FAIL reset cyc=%0d got=%h want=%h", i, obs, out_t'(0));
      end
    end
    rst_n = 1'b1;
    tick;
    c = busy_cyc(0); c.pc_en = 1'b1; c.ir_ld = 1'b1;
    total++;
    if (obs !== c) begin
      bad++;
      $display("FAIL reset_release got=%h want=%h", obs, c);
    end
    clr = 1'b1;
    tick;
    clr = 1'b0;
    run = 1'b0;
    total++;
    if (obs !== out_t'(0)) begin
      bad++;
      $display("FAIL clr_fetch got=%h want=%h", obs, out_t'(0));
    end
  endtask

  task automatic test_alu;
    bit          in_fetch;
    bit          re;
    logic [3:0]  opcs [5];
    opcs = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5};
    start_from_idle;
    run_instr(4'd1, 0, 1'b1, "sub");
    run_instr(4'd1, 0, 1'b0, "sub2");
    in_fetch = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!in_fetch) start_from_idle;
      re = (i == 19) ? 1'b0 : 1'($urandom);
      run_instr(opcs[$urandom_range(0, 4)], 0, re, "alu_ld");
      in_fetch = re;
    end
  endtask

  task automatic test_mul;
    start_from_idle;
    run_instr(4'd4, 3, 1'b0, "mul3");
    start_from_idle;
    run_instr(4'd4, 15, 1'b0, "mul15");
    start_from_idle;
    run_instr(4'd4, 1, 1'b0, "mul1");
    for (int i = 0; i < 4; i++) begin
      start_from_idle;
      run_instr(4'd4, $urandom_range(1, 15), 1'b0, "mul_rand");
    end
  endtask

  task automatic test_timeout;
    start_from_idle;
    run_instr(4'd4, 0, 1'b0, "mul_timeout");
  endtask

  task automatic test_store;
    start_from_idle;
    run_instr(4'd6, 0, 1'b0, "st_idle");
    start_from_idle;
    run_instr(4'd6, 0, 1'b1, "st_chain");
    run_instr(4'd0, 0, 1'b0, "after_st");
  endtask

  task automatic test_illegal_halt;
    start_from_idle;
    run_instr(4'd8, 0, 1'b0, "illegal8");
    start_from_idle;
    run_instr(4'($urandom_range(9, 15)), 0, 1'b0, "illegal");
    start_from_idle;
    run_instr(4'd7, 0, 1'b0, "halt");
  endtask

  task automatic test_back_to_back;
    logic [3:0] o;
    start_from_idle;
    for (int i = 0; i < 12; i++) begin
      o = 4'($urandom_range(0, 6));
      run_instr(o, (o == 4) ? $urandom_range(1, 6) : 0, (i != 11), "b2b");
    end
  endtask

  task automatic test_rst_mid;
    start_from_idle;
    instr = 16'h2abc;
    tick;
    tick;
    total++;
    if (obs !== {7'b0, 3'b010, 4'd2, 3'b100}) begin
      bad++;
      $display("FAIL rst_mid_exec got=%h want=%h", obs, {7'b0, 3'b010, 4'd2, 3'b100});
    end
    rst_n = 1'b0;
    tick;
    total++;
    if (obs !== out_t'(0)) begin
      bad++;
      $display("FAIL rst_mid got=%h want=%h", obs, out_t'(0));
    end
    rst_n = 1'b1;
    run   = 1'b0;
    tick;
    total++;
    if (obs !== out_t'(0)) begin
      bad++;
      $display("FAIL rst_mid_hold got=%h want=%h", obs, out_t'(0));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_alu;
    test_mul;
    test_timeout;
    test_store;
    test_illegal_halt;
    test_back_to_back;
    test_rst_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
